output_merge_arbiter: RTL and testbench

OUTPUT_MERGE_ARBITER -- requirements
Module: output_merge_arbiter

---
 rtl/output_merge_arbiter.sv | 110 +++++++++++
 tb/tb_output_merge_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_merge_arbiter.sv
// Round-robin merge of NUM_IN packet flows into one output link through a
// DEPTH-entry FIFO, with a saturating count of delivered packets.
module output_merge_arbiter #(
  parameter int WIDTH  = 39,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [15:0]             pkt_count
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int unsigned NI = NUM_IN;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      pkt_q, pkt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [NUM_IN-1:0] grant;
  logic [PW-1:0]     gidx, cand;
  logic              found, space, push, pop;
  logic [WIDTH-1:0]  push_data;

  assign space     = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_q];
  assign pkt_count = pkt_q;
  assign pop       = out_valid && out_ready;
  assign push      = |grant;

  // Grant is gated by rst_n so nothing is accepted while reset is held,
  // and deliberately ignores out_ready: a full buffer never accepts.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NI; k++) begin
      cand = PW'((32'(ptr_q) + k) % NI);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    if (found && space && rst_n) grant[gidx] = 1'b1;
  end

  assign in_ready = grant;

  always_comb begin
    push_data = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      if (gidx == PW'(k)) push_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    pkt_d = pkt_q;
    if (push) begin
      ptr_d = (gidx == PW'(NI - 1)) ? '0 : gidx + 1'b1;
      wr_d  = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      if (pkt_q != '1) pkt_d = pkt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      pkt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
    end
  end

  // Storage is not reset; its contents are only observed while out_valid=1.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: tb/tb_output_merge_arbiter.sv
// Directed bench for output_merge_arbiter: reset, single packet, round robin,
// backpressure, simultaneous push/pop and asynchronous mid-run reset.
module tb_output_merge_arbiter;

  localparam int W = 39;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [15:0]    pkt_count;

  int vectors;
  int miscompares;

  output_merge_arbiter #(.WIDTH(39), .NUM_IN(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pkt(input int i);
    pkt = {2'b10, 4'(i), 4'(i + 1), 29'(i * 1000 + 7)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pkt(input int i, input logic [W-1:0] p);
    in_data[i*W +: W] = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_in_ready cyc%0d: got %b expected 0000", c, in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid cyc%0d: got %b expected 0", c, out_valid);
      end
      vectors++;
      if (pkt_count !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_pkt_count cyc%0d: got %0d expected 0", c, pkt_count);
      end
    end
    in_valid = '0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] p;
    p = 39'b01_0001_0001_00000_00001110_00000101_00001000;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    set_pkt(2, p);
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_in_ready: got %b expected 0100", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_bypass: got %b expected 0", out_valid);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== p) begin
      miscompares++;
      $display("FAIL single_out: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, p);
    end
    vectors++;
    if (pkt_count !== 16'd0) begin
      miscompares++;
      $display("FAIL single_count_before: got %0d expected 0", pkt_count);
    end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pkt_count !== 16'd1) begin
      miscompares++;
      $display("FAIL single_count_after: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, pkt_count);
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < N; i++) set_pkt(i, pkt(i));
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        in_valid = 4'b1111;
        exp_rdy  = 4'b0001 << order[c];
      end else begin
        in_valid = 4'b0000;
        exp_rdy  = 4'b0000;
      end
      #1;
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_grant cyc%0d: got %b expected %b", c, in_ready, exp_rdy);
      end
      if (c > 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== pkt(order[c-1])) begin
          miscompares++;
          $display("FAIL rr_out cyc%0d: got v=%b d=%h expected v=1 d=%h",
                   c, out_valid, out_data, pkt(order[c-1]));
        end
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rr_out cyc0: got v=%b expected 0", out_valid);
        end
      end
      tick();
    end
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pkt_count !== 16'd6) begin
      miscompares++;
      $display("FAIL rr_drain: got v=%b cnt=%0d expected v=0 cnt=6", out_valid, pkt_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) set_pkt(i, pkt(i));
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_grant0: got %b expected 0001", in_ready);
    end
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b0010 || out_valid !== 1'b1 || out_data !== pkt(0)) begin
      miscompares++;
      $display("FAIL bp_grant1: got rdy=%b v=%b d=%h expected rdy=0010 v=1 d=%h",
               in_ready, out_valid, out_data, pkt(0));
    end
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b0000 || out_data !== pkt(0)) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b d=%h expected rdy=0000 d=%h", in_ready, out_data, pkt(0));
    end
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== pkt(0)) begin
      miscompares++;
      $display("FAIL bp_hold: got rdy=%b v=%b d=%h expected rdy=0000 v=1 d=%h",
               in_ready, out_valid, out_data, pkt(0));
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_full_pop: got %b expected 0000", in_ready);
    end
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b0001 || out_data !== pkt(1)) begin
      miscompares++;
      $display("FAIL bp_resume: got rdy=%b d=%h expected rdy=0001 d=%h", in_ready, out_data, pkt(1));
    end
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b0010 || out_data !== pkt(0)) begin
      miscompares++;
      $display("FAIL bp_order: got rdy=%b d=%h expected rdy=0010 d=%h", in_ready, out_data, pkt(0));
    end
    in_valid = '0;
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pkt_count !== 16'd3) begin
      miscompares++;
      $display("FAIL bp_drain: got v=%b cnt=%0d expected v=0 cnt=3", out_valid, pkt_count);
    end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] pa, pb;
    pa = 39'h2A_AAAA_5555;
    pb = 39'h15_5555_AAAA;
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_pkt(0, pa);
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL pp_grant0: got %b expected 0001", in_ready);
    end
    tick();
    in_valid  = 4'b1000;
    set_pkt(3, pb);
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b1000 || out_data !== pa) begin
      miscompares++;
      $display("FAIL pp_grant3: got rdy=%b d=%h expected rdy=1000 d=%h", in_ready, out_data, pa);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== pb) begin
      miscompares++;
      $display("FAIL pp_head: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, pb);
    end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pp_occ1: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] pc;
    pc = 39'h7F_0F0F_0F0F;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    #1;
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL mr_fill1: got %b expected 0010", in_ready);
    end
    tick();
    in_valid = 4'b0100;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL mr_fill2: got %b expected 0100", in_ready);
    end
    tick();
    in_valid = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1 || pkt_count !== 16'd5) begin
      miscompares++;
      $display("FAIL mr_full: got rdy=%b v=%b cnt=%0d expected rdy=0000 v=1 cnt=5",
               in_ready, out_valid, pkt_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || pkt_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mr_async: got v=%b rdy=%b cnt=%0d expected v=0 rdy=0000 cnt=0",
               out_valid, in_ready, pkt_count);
    end
    in_valid = '0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 4'b1010;
    set_pkt(1, pc);
    #1;
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL mr_first_grant: got %b expected 0010", in_ready);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== pc) begin
      miscompares++;
      $display("FAIL mr_after: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, pc);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = '0;
    in_data     = '0;
    out_ready   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
